// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator/arbiter: round-robin pops one packet per bus and pushes it to its destination device(s).
// Optional broadcast fan-out is enabled by defining BS_BROADCAST_EN.
module bs_gnrtr_n_rbtr #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]             pop,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int unsigned IW  = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam int unsigned IW1 = IW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t              state_q, state_d;
        logic [IW-1:0]       rr_q, rr_d;
        logic [IW-1:0]       grant_q, grant_d;
        logic [drvrs-1:0]    pop_q, pop_d;
        logic [drvrs-1:0]    push_q, push_d;
        logic [pckg_sz-1:0]  pkt_q, pkt_d;
        logic [IW-1:0]       pick_c;
        logic                any_c;
        logic [pckg_sz-1:0]  head_c;
        logic [7:0]          dest_c;

        // Cyclic search for the first pending device after the rr pointer
        always_comb begin : rr_search
            logic [IW1-1:0] idx;
            idx    = '0;
            pick_c = rr_q;
            any_c  = 1'b0;
            for (int unsigned k = 1; k <= drvrs; k++) begin
                idx = IW1'(rr_q) + IW1'(k);
                if (idx >= IW1'(drvrs)) begin
                    idx = idx - IW1'(drvrs);
                end
                if (!any_c && pndng[b][idx[IW-1:0]]) begin
                    any_c  = 1'b1;
                    pick_c = idx[IW-1:0];
                end
            end
        end

        assign head_c = D_pop[b][grant_q];
        assign dest_c = head_c[pckg_sz-1 -: 8];

        // Next-state and next-output logic
        always_comb begin
            state_d = state_q;
            rr_d    = rr_q;
            grant_d = grant_q;
            pop_d   = '0;
            push_d  = '0;
            pkt_d   = pkt_q;
            case (state_q)
                IDLE: begin
                    if (any_c) begin
                        grant_d        = pick_c;
                        rr_d           = pick_c;
                        pop_d[pick_c]  = 1'b1;
                        state_d        = POP;
                    end
                end
                POP: begin
                    pkt_d = head_c;
                    for (int unsigned i = 0; i < drvrs; i++) begin
                        if (dest_c == 8'(i)) begin
                            push_d[i] = 1'b1;
                        end
                    end
`ifdef BS_BROADCAST_EN
                    if (dest_c == broadcast) begin
                        for (int unsigned i = 0; i < drvrs; i++) begin
                            push_d[i] = (IW'(i) != grant_q);
                        end
                    end
`endif
                    state_d = PUSH;
                end
                PUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // State and registered outputs; rr pointer resets to last device so device 0 wins first
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                rr_q    <= IW'(drvrs - 1);
                grant_q <= '0;
                pop_q   <= '0;
                push_q  <= '0;
                pkt_q   <= '0;
            end else begin
                state_q <= state_d;
                rr_q    <= rr_d;
                grant_q <= grant_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
                pkt_q   <= pkt_d;
            end
        end

        assign pop[b]  = pop_q;
        assign push[b] = push_q;

        for (genvar i = 0; i < drvrs; i++) begin : g_dpush
            assign D_push[b][i] = pkt_q;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench for bs_gnrtr_n_rbtr (bits=1, drvrs=4, pckg_sz=16); broadcast expectation follows BS_BROADCAST_EN.
module tb_bs_gnrtr_n_rbtr;

    logic                        clk;
    logic                        reset;
    logic [0:0][3:0]             pndng;
    logic [0:0][3:0][15:0]       D_pop;
    logic [0:0][3:0]             pop;
    logic [0:0][3:0]             push;
    logic [0:0][3:0][15:0]       D_push;

    int checks = 0;
    int errors = 0;

`ifdef BS_BROADCAST_EN
    localparam logic [3:0] BC_PUSH = 4'b1110;
`else
    localparam logic [3:0] BC_PUSH = 4'b0000;
`endif

    bs_gnrtr_n_rbtr #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    logic [15:0] rr_data [4];
    logic [3:0]  rr_push [4];

    initial begin
        rr_data = '{16'h0110, 16'h0221, 16'h0332, 16'h0043};
        rr_push = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_pop", 32'(pop[0]), 32'h0);
        check("reset_push", 32'(push[0]), 32'h0);
        check("reset_dpush", 32'(D_push[0][2]), 32'h0);
        tick();
        tick();
        check("idle_pop", 32'(pop[0]), 32'h0);
        check("idle_push", 32'(push[0]), 32'h0);

        // Unicast dev1 -> dev2
        D_pop[0][1] = 16'h02AB;
        pndng[0]    = 4'b0010;
        tick();
        check("uni_pop", 32'(pop[0]), 32'h2);
        check("uni_pop_push", 32'(push[0]), 32'h0);
        pndng[0] = 4'b0000;
        tick();
        check("uni_push", 32'(push[0]), 32'h4);
        check("uni_push_pop", 32'(pop[0]), 32'h0);
        check("uni_dpush2", 32'(D_push[0][2]), 32'h02AB);
        tick();
        check("uni_after_push", 32'(push[0]), 32'h0);
        check("uni_dpush_hold", 32'(D_push[0][0]), 32'h02AB);

        // Broadcast from dev0
        D_pop[0][0] = 16'hFF55;
        pndng[0]    = 4'b0001;
        tick();
        check("bc_pop", 32'(pop[0]), 32'h1);
        pndng[0] = 4'b0000;
        tick();
        check("bc_push", 32'(push[0]), 32'(BC_PUSH));
        check("bc_dpush3", 32'(D_push[0][3]), 32'hFF55);
        tick();
        check("bc_after_push", 32'(push[0]), 32'h0);

        // Invalid destination from dev3
        D_pop[0][3] = 16'h0711;
        pndng[0]    = 4'b1000;
        tick();
        check("inv_pop", 32'(pop[0]), 32'h8);
        pndng[0] = 4'b0000;
        tick();
        check("inv_push", 32'(push[0]), 32'h0);
        check("inv_pop_once", 32'(pop[0]), 32'h0);
        tick();
        check("inv_after", 32'(push[0] | pop[0]), 32'h0);

        // Self-addressed packet still delivered to source
        D_pop[0][2] = 16'h0299;
        pndng[0]    = 4'b0100;
        tick();
        check("self_pop", 32'(pop[0]), 32'h4);
        pndng[0] = 4'b0000;
        tick();
        check("self_push", 32'(push[0]), 32'h4);
        tick();

        // Round-robin with all devices permanently pending after reset
        reset = 1'b1;
        for (int i = 0; i < 4; i++) D_pop[0][i] = rr_data[i];
        pndng[0] = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("rr%0d_pop", n), 32'(pop[0]), 32'(4'b0001 << (n % 4)));
            check($sformatf("rr%0d_pop_push", n), 32'(push[0]), 32'h0);
            tick();
            check($sformatf("rr%0d_push", n), 32'(push[0]), 32'(rr_push[n % 4]));
            check($sformatf("rr%0d_dpush", n), 32'(D_push[0][0]), 32'(rr_data[n % 4]));
            tick();
            check($sformatf("rr%0d_idle", n), 32'(pop[0] | push[0]), 32'h0);
        end

        // Reset during POP aborts the packet; next grant restarts at dev0
        tick();
        check("mid_pop", 32'(pop[0]), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_push", 32'(push[0]), 32'h0);
        check("mid_pop_clr", 32'(pop[0]), 32'h0);
        check("mid_dpush", 32'(D_push[0][1]), 32'h0);
        tick();
        check("mid_regrant", 32'(pop[0]), 32'h1);
        tick();
        check("mid_regrant_push", 32'(push[0]), 32'h2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
